jsq_pulse_gen: RTL and testbench

- Parametrised successor of the single-channel en-triggered counter.
- A one-cycle start strobe launches a programmable pulse train on dout: an initial delay, then a number of high pulses separated by low gaps.
- Phase lengths and repeat count are runtime inputs, latched at start.
- Used as the timing generator for LED/strobe/enable sequencing in the study designs.

---
 rtl/jsq_pkg.sv | 16 +
 rtl/jsq_down_cnt.sv | 38 +++
 rtl/jsq_pulse_gen.sv | 162 ++++++++++++++++
 tb/tb_jsq_pulse_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jsq_pkg.sv
// jsq_pkg: state encoding and length helpers shared by the
// jsq_pulse_gen pulse-train generator.
package jsq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_e;

   function automatic logic [31:0] clamp1(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/jsq_down_cnt.sv
// jsq_down_cnt: loadable down-counter that saturates at zero.
// Load has priority over decrement.
module jsq_down_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/jsq_pulse_gen.sv
// jsq_pulse_gen: start-strobed delay / high / low pulse train.
// Define JSQ_PULSE_GEN_RETRIG_EN to let en restart a running sequence.
module jsq_pulse_gen
   import jsq_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_low,
   input  logic [REP_W-1:0] cfg_rep,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   state_e state_q, state_d;

   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic             fin_q, fin_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             start;
   logic             ph_load, ph_dec, ph_zero;
   logic [CNT_W-1:0] ph_ld_val, ph_val;
   logic             rp_load, rp_dec, rp_zero;
   logic [REP_W-1:0] rp_ld_val, rp_val;
   logic             unused_cnt;

   function automatic logic [CNT_W-1:0] len_m1(
      input logic [CNT_W-1:0] v
   );
      return CNT_W'(clamp1(32'(v)) - 32'd1);
   endfunction

`ifdef JSQ_PULSE_GEN_RETRIG_EN
   assign start = en;
`else
   assign start = en && (state_q == ST_IDLE);
`endif

   jsq_down_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ph_load),
      .load_val (ph_ld_val),
      .dec      (ph_dec),
      .value    (ph_val),
      .zero     (ph_zero)
   );

   jsq_down_cnt #(.W(REP_W)) u_pulse_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rp_load),
      .load_val (rp_ld_val),
      .dec      (rp_dec),
      .value    (rp_val),
      .zero     (rp_zero)
   );

   assign unused_cnt = ^{ph_val, rp_val};

   // Counters hold "cycles left minus one", so zero marks a phase's last cycle.
   always_comb begin
      state_d   = state_q;
      high_d    = high_q;
      low_d     = low_q;
      fin_d     = 1'b0;
      ph_load   = 1'b0;
      ph_dec    = 1'b0;
      ph_ld_val = '0;
      rp_load   = 1'b0;
      rp_dec    = 1'b0;
      rp_ld_val = '0;
      if (start) begin
         high_d    = cfg_high;
         low_d     = cfg_low;
         rp_load   = 1'b1;
         rp_ld_val = REP_W'(clamp1(32'(cfg_rep)) - 32'd1);
         ph_load   = 1'b1;
         if (cfg_delay == '0) begin
            state_d   = ST_HIGH;
            ph_ld_val = len_m1(cfg_high);
         end else begin
            state_d   = ST_DELAY;
            ph_ld_val = cfg_delay - CNT_W'(1);
         end
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_DELAY: begin
               if (ph_zero) begin
                  state_d   = ST_HIGH;
                  ph_load   = 1'b1;
                  ph_ld_val = len_m1(high_q);
               end else begin
                  ph_dec = 1'b1;
               end
            end
            ST_HIGH: begin
               if (ph_zero && rp_zero) begin
                  state_d = ST_IDLE;
                  fin_d   = 1'b1;
               end else if (ph_zero) begin
                  state_d   = ST_LOW;
                  ph_load   = 1'b1;
                  ph_ld_val = len_m1(low_q);
                  rp_dec    = 1'b1;
               end else begin
                  ph_dec = 1'b1;
               end
            end
            ST_LOW: begin
               if (ph_zero) begin
                  state_d   = ST_HIGH;
                  ph_load   = 1'b1;
                  ph_ld_val = len_m1(high_q);
               end else begin
                  ph_dec = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      dout_d = (state_q == ST_HIGH);
      busy_d = (state_q != ST_IDLE);
      done_d = fin_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         high_q  <= '0;
         low_q   <= '0;
         fin_q   <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         high_q  <= high_d;
         low_q   <= low_d;
         fin_q   <= fin_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign dout = dout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_jsq_pulse_gen.sv
// tb_jsq_pulse_gen: directed-vector bench for jsq_pulse_gen.
// Expected traces are indexed by edges after the start edge k.
module tb_jsq_pulse_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] cfg_delay = '0;
   logic [7:0] cfg_high = '0;
   logic [7:0] cfg_low = '0;
   logic [3:0] cfg_rep = '0;
   logic       dout;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   jsq_pulse_gen #(.CNT_W(8), .REP_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_delay (cfg_delay),
      .cfg_high  (cfg_high),
      .cfg_low   (cfg_low),
      .cfg_rep   (cfg_rep),
      .dout      (dout),
      .busy      (busy),
      .done      (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] d, input logic [7:0] h,
                         input logic [7:0] l, input logic [3:0] r);
      cfg_delay = d;
      cfg_high  = h;
      cfg_low   = l;
      cfg_rep   = r;
      en        = 1'b1;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en = ~en;
         tick();
         checks++;
         if ({dout, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold cyc%0d got=%b%b%b exp=000",
                     i, dout, busy, done);
         end
      end
      en    = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if ({dout, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got=%b%b%b exp=000",
                  dout, busy, done);
      end
   endtask

   task automatic test_single();
      logic [4:0] ed, eb, ec;
      ed = 5'b11110;
      eb = 5'b11110;
      ec = 5'b00001;
      launch(8'd0, 8'd4, 8'd0, 4'd1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if ({dout, busy, done} !== {ed[5-i], eb[5-i], ec[5-i]}) begin
            errors++;
            $display("FAIL single k+%0d got=%b%b%b exp=%b%b%b", i,
                     dout, busy, done, ed[5-i], eb[5-i], ec[5-i]);
         end
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_len got=%b exp=0", done);
      end
   endtask

   task automatic test_train();
      logic [15:0] ed, eb, ec;
      ed = 16'b0001100011000110;
      eb = 16'b1111111111111110;
      ec = 16'b0000000000000001;
      launch(8'd3, 8'd2, 8'd3, 4'd3);
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if ({dout, busy, done} !== {ed[16-i], eb[16-i], ec[16-i]}) begin
            errors++;
            $display("FAIL train k+%0d got=%b%b%b exp=%b%b%b", i,
                     dout, busy, done, ed[16-i], eb[16-i], ec[16-i]);
         end
      end
      tick();
      checks++;
      if ({dout, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL train_after got=%b%b%b exp=000",
                  dout, busy, done);
      end
   endtask

   task automatic test_zero_clamp();
      logic [1:0] ed, eb, ec;
      ed = 2'b10;
      eb = 2'b10;
      ec = 2'b01;
      launch(8'd0, 8'd0, 8'd0, 4'd0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++;
         if ({dout, busy, done} !== {ed[2-i], eb[2-i], ec[2-i]}) begin
            errors++;
            $display("FAIL zero_clamp k+%0d got=%b%b%b exp=%b%b%b", i,
                     dout, busy, done, ed[2-i], eb[2-i], ec[2-i]);
         end
      end
      tick();
      checks++;
      if ({dout, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL zero_clamp_after got=%b%b%b exp=000",
                  dout, busy, done);
      end
   endtask

   task automatic test_en_busy();
      logic [15:0] ed, eb, ec;
      int n;
      int dcnt;
`ifdef JSQ_PULSE_GEN_RETRIG_EN
      n  = 10;
      ed = 16'b0001101010;
      eb = 16'b1111111110;
      ec = 16'b0000000001;
`else
      n  = 16;
      ed = 16'b0001100011000110;
      eb = 16'b1111111111111110;
      ec = 16'b0000000000000001;
`endif
      dcnt = 0;
      launch(8'd3, 8'd2, 8'd3, 4'd3);
      for (int i = 1; i <= n; i++) begin
         tick();
         if (i == 6) en = 1'b0;
         dcnt += int'(done);
         checks++;
         if ({dout, busy, done} !== {ed[n-i], eb[n-i], ec[n-i]}) begin
            errors++;
            $display("FAIL en_busy k+%0d got=%b%b%b exp=%b%b%b", i,
                     dout, busy, done, ed[n-i], eb[n-i], ec[n-i]);
         end
         if (i == 5) begin
            cfg_delay = 8'd0;
            cfg_high  = 8'd1;
            cfg_low   = 8'd1;
            cfg_rep   = 4'd2;
            en        = 1'b1;
         end
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         dcnt += int'(done);
      end
      checks++;
      if (dcnt != 1) begin
         errors++;
         $display("FAIL en_busy_done_count got=%0d exp=1", dcnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL en_busy_idle got=%b exp=0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] ed, eb, ec;
      ed = 11'b11110001010;
      eb = 11'b11110111110;
      ec = 11'b00001000001;
      launch(8'd0, 8'd4, 8'd0, 4'd1);
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 5) en = 1'b0;
         checks++;
         if ({dout, busy, done} !== {ed[11-i], eb[11-i], ec[11-i]}) begin
            errors++;
            $display("FAIL back_to_back k+%0d got=%b%b%b exp=%b%b%b", i,
                     dout, busy, done, ed[11-i], eb[11-i], ec[11-i]);
         end
         if (i == 1) begin
            cfg_delay = 8'd2;
            cfg_high  = 8'd1;
            cfg_low   = 8'd1;
            cfg_rep   = 4'd2;
         end
         if (i == 4) en = 1'b1;
      end
      tick();
      checks++;
      if ({dout, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL back_to_back_after got=%b%b%b exp=000",
                  dout, busy, done);
      end
   endtask

   task automatic test_max();
      int rise;
      int highs;
      int done_at;
      rise    = 0;
      highs   = 0;
      done_at = 0;
      launch(8'd255, 8'd255, 8'd0, 4'd1);
      for (int i = 1; i <= 600; i++) begin
         tick();
         if (dout === 1'b1 && rise == 0) rise = i;
         if (dout === 1'b1) highs++;
         if (done === 1'b1) begin
            done_at = i;
            break;
         end
      end
      checks++;
      if (rise != 256) begin
         errors++;
         $display("FAIL max_delay rise_at=k+%0d exp=k+256", rise);
      end
      checks++;
      if (highs != 255) begin
         errors++;
         $display("FAIL max_high cycles=%0d exp=255", highs);
      end
      checks++;
      if (done_at != 511) begin
         errors++;
         $display("FAIL max_done done_at=k+%0d exp=k+511", done_at);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      launch(8'd0, 8'd4, 8'd0, 4'd1);
      tick();
      checks++;
      if ({dout, busy} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_pre got=%b%b exp=11", dout, busy);
      end
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({dout, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid got=%b%b%b exp=000",
                  dout, busy, done);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if ({dout, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_after cyc%0d got=%b%b%b exp=000",
                     i, dout, busy, done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_train();
      test_zero_clamp();
      test_en_busy();
      test_back_to_back();
      test_max();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
